// File: rtl/seq_detector_counter.sv
// Serial PAT_LEN-bit pattern detector with per-period saturating hit counter.
// Build option: define SEQ_DET_OVERLAP_EN to count overlapping matches.
module seq_detector_counter #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bit_in,
  input  logic             period_tick,
  output logic             det_pulse,
  output logic [CNT_W-1:0] count_out,
  output logic             count_sat,
  output logic             count_valid
);
  localparam int                FILL_W    = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic               run_sat_q, run_sat_d;
  logic               det_q, det_d;
  logic [CNT_W-1:0]   cnt_out_q, cnt_out_d;
  logic               cnt_sat_q, cnt_sat_d;
  logic               cv_q, cv_d;

  logic [PAT_LEN-1:0] win;
  logic               full;
  logic               hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q    <= '0;
      fill_q    <= '0;
      run_cnt_q <= '0;
      run_sat_q <= 1'b0;
      det_q     <= 1'b0;
      cnt_out_q <= '0;
      cnt_sat_q <= 1'b0;
      cv_q      <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      run_cnt_q <= run_cnt_d;
      run_sat_q <= run_sat_d;
      det_q     <= det_d;
      cnt_out_q <= cnt_out_d;
      cnt_sat_q <= cnt_sat_d;
      cv_q      <= cv_d;
    end
  end

  // fill saturates at PAT_LEN-1, so "full" means PAT_LEN-1 bits are already
  // banked and the incoming bit completes a valid window.
  always_comb begin
    win  = {hist_q, bit_in};
    full = (fill_q == FILL_FULL);
    hit  = en && full && (win == PATTERN);
  end

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    run_cnt_d = run_cnt_q;
    run_sat_d = run_sat_q;
    cnt_out_d = cnt_out_q;
    cnt_sat_d = cnt_sat_q;
    det_d     = hit;
    cv_d      = 1'b0;
    if (en) begin
      hist_d = win[PAT_LEN-2:0];
      if (!full) fill_d = fill_q + FILL_W'(1);
`ifndef SEQ_DET_OVERLAP_EN
      // Non-overlapping: a match consumes its bits, next one needs a fresh window.
      if (hit) begin
        hist_d = '0;
        fill_d = '0;
      end
`endif
      if (period_tick) begin
        // Boundary bit belongs to the new period; publish the old one untouched.
        cnt_out_d = run_cnt_q;
        cnt_sat_d = run_sat_q;
        cv_d      = 1'b1;
        run_cnt_d = CNT_W'(hit);
        run_sat_d = 1'b0;
      end else if (hit) begin
        if (run_cnt_q == CNT_MAX) run_sat_d = 1'b1;
        else                      run_cnt_d = run_cnt_q + CNT_W'(1);
      end
    end
  end

  assign det_pulse   = det_q;
  assign count_out   = cnt_out_q;
  assign count_sat   = cnt_sat_q;
  assign count_valid = cv_q;

endmodule

// File: tb/tb_seq_detector_counter.sv
// Randomized + directed bench for seq_detector_counter against a queue-based model.
module tb_seq_detector_counter;
  localparam int PAT_LEN = 4;
  localparam int PATTERN = 'b1011;

  logic        clk = 1'b0;
  logic        reset, en, bit_in, period_tick;
  logic        det_a, cs_a, cv_a;
  logic [15:0] co_a;
  logic        det_b, cs_b, cv_b;
  logic [3:0]  co_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  always #5 clk = ~clk;

  seq_detector_counter #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .en(en), .bit_in(bit_in), .period_tick(period_tick),
    .det_pulse(det_a), .count_out(co_a), .count_sat(cs_a), .count_valid(cv_a));

  seq_detector_counter #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .en(en), .bit_in(bit_in), .period_tick(period_tick),
    .det_pulse(det_b), .count_out(co_b), .count_sat(cs_b), .count_valid(cv_b));

  // Model: bits seen since reset/last consumed match, hits this period, hits published.
  bit          mq[$];
  int unsigned hits = 0;
  int unsigned pub  = 0;
  bit          e_det = 0, e_cv = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit b, input bit t);
    int v;
    bit h;
    e_det = 0;
    e_cv  = 0;
    if (r) begin
      mq.delete();
      hits = 0;
      pub  = 0;
      return;
    end
    if (!e) return;
    mq.push_back(b);
    if (mq.size() > PAT_LEN) void'(mq.pop_front());
    h = 0;
    if (mq.size() == PAT_LEN) begin
      v = 0;
      foreach (mq[i]) v = (v << 1) | int'(mq[i]);
      h = (v == PATTERN);
    end
`ifndef SEQ_DET_OVERLAP_EN
    if (h) mq.delete();
`endif
    e_det = h;
    if (t) begin
      pub  = hits;
      hits = h;
      e_cv = 1;
    end else begin
      hits += h;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit b, input bit t);
    reset = r; en = e; bit_in = b; period_tick = t;
    @(posedge clk);
    model_update(r, e, b, t);
    @(negedge clk);
  endtask

  task automatic bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, 1, v[i], 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("det_a", det_a, e_det);
      chk("cv_a",  cv_a,  e_cv);
      chk("co_a",  co_a,  (pub > 65535) ? 65535 : pub);
      chk("cs_a",  cs_a,  pub > 65535);
      chk("det_b", det_b, e_det);
      chk("cv_b",  cv_b,  e_cv);
      chk("co_b",  co_b,  (pub > 15) ? 15 : pub);
      chk("cs_b",  cs_b,  pub > 15);
    end
  end

  initial begin
    int dets;
    reset = 1; en = 1; bit_in = 1; period_tick = 0;
    // T1: reset with en=1, bit_in=1
    step(1, 1, 1, 0);
    chk_en = 1;
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("t1_rst_co", co_a, 0);
    chk("t1_rst_det", det_a, 0);
    dets = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0);
      dets += det_a;
    end
    chk("t1_nodet_first3", dets, 0);

    // T2: 1,0,1,1,0,1,1 then tick with 0
    step(1, 1, 0, 0);
    bits(32'b1011, 4);
    chk("t2_det4", det_a, 1);
    bits(32'b011, 3);
`ifdef SEQ_DET_OVERLAP_EN
    chk("t2_det7", det_a, 1);
`else
    chk("t2_det7", det_a, 0);
`endif
    step(0, 1, 0, 1);
    chk("t2_cv", cv_a, 1);
`ifdef SEQ_DET_OVERLAP_EN
    chk("t2_co", co_a, 2);
`else
    chk("t2_co", co_a, 1);
`endif

    // T3: hit on the boundary bit counts in the new period
    step(1, 1, 0, 0);
    bits(32'b101, 3);
    step(0, 1, 1, 1);
    chk("t3_co_excl", co_a, 0);
    chk("t3_det", det_a, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    chk("t3_co_next", co_a, 1);

    // T4: 20 matches in one period on the 4-bit counter
    step(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) bits(32'b1011, 4);
    step(0, 1, 0, 1);
    chk("t4_co_sat", co_b, 15);
    chk("t4_cs_sat", cs_b, 1);
    chk("t4_co_wide", co_a, 20);
    chk("t4_cs_wide", cs_a, 0);
    step(0, 1, 0, 1);
    chk("t4_co_empty", co_b, 0);
    chk("t4_cs_empty", cs_b, 0);

    // T5: en gaps mid-pattern, tick held while disabled
    step(1, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 1);
    chk("t5_cv_gap", cv_a, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 1, 0);
    step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    chk("t5_det", det_a, 1);
    step(0, 1, 0, 1);
    chk("t5_co", co_a, 1);

    // Random phase, pattern bursts mixed in to stress overlap and saturation
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 3; k >= 0; k--)
          step(0, $urandom_range(0, 9) != 0, PATTERN[k], $urandom_range(0, 31) == 0);
      end else begin
        step($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 23) == 0);
      end
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
